// File: rtl/fp_result_queue.sv
// Credit-managed result FIFO that sits behind a fixed-latency FP adder.
// Define FP_RESULT_QUEUE_CLASSIFY_EN to store nan/inf/zero class bits with each entry.
module fp_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_i,
  input  logic                    flag_i,
  input  logic [31:0]             c_i,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [31:0]             out_data,
  output logic [2:0]              out_class,
  output logic                    credit_ok,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err_overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned IMAX = LAT + DEPTH;
  localparam int unsigned IW   = $clog2(IMAX + 1);
  localparam int unsigned SW   = ((CW > IW) ? CW : IW) + 1;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [IW-1:0] IMaxC  = IW'(IMAX);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_infl;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_d;
  logic [IW-1:0] w_infl_d;
  logic [SW-1:0] w_sum;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  // A full queue still accepts a result when the head leaves in the same cycle.
  assign w_push    = flag_i & ((r_count < DepthC) | w_pop);
  assign w_drop    = flag_i & ~w_push;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  // In-flight tracking saturates high and never underflows on spurious results.
  always_comb begin
    w_infl_d = r_infl;
    if (issue_i && !flag_i) begin
      if (r_infl != IMaxC) w_infl_d = r_infl + IW'(1);
    end else if (flag_i && !issue_i) begin
      if (r_infl != '0) w_infl_d = r_infl - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_infl  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_d;
      r_infl  <= w_infl_d;
      if (w_drop) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wptr] <= c_i;
  end

  assign out_data     = r_mem[r_rptr];
  assign count        = r_count;
  assign err_overflow = r_err;

  assign w_sum     = SW'(r_count) + SW'(r_infl);
  assign credit_ok = (w_sum < SW'(DEPTH));

`ifdef FP_RESULT_QUEUE_CLASSIFY_EN
  logic [2:0] r_cls [DEPTH];
  logic       w_exp_ones;
  logic       w_exp_zero;
  logic       w_man_zero;
  logic [2:0] w_cls;

  assign w_exp_ones = (c_i[30:23] == 8'hFF);
  assign w_exp_zero = (c_i[30:23] == 8'h00);
  assign w_man_zero = (c_i[22:0] == 23'd0);
  // Bit order {nan, inf, zero}.
  assign w_cls      = {w_exp_ones & ~w_man_zero, w_exp_ones & w_man_zero, w_exp_zero & w_man_zero};

  always_ff @(posedge clk) begin
    if (rst && w_push) r_cls[r_wptr] <= w_cls;
  end

  assign out_class = r_cls[r_rptr];
`else
  assign out_class = 3'b000;
`endif

endmodule

// File: tb/tb_fp_result_queue.sv
// Scoreboard bench for fp_result_queue: driver predicts accepted results, monitor checks the head.
// Honours FP_RESULT_QUEUE_CLASSIFY_EN the same way the design does.
module tb_fp_result_queue;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_i = 1'b0;
  logic        flag_i = 1'b0;
  logic [31:0] c_i = 32'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_class;
  logic        credit_ok;
  logic [2:0]  count;
  logic        err_overflow;

  fp_result_queue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (issue_i),
    .flag_i       (flag_i),
    .c_i          (c_i),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_class    (out_class),
    .credit_ok    (credit_ok),
    .count        (count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          checking = 0;
  logic [31:0] sb[$];
  int          mcount = 0;
  int          minfl = 0;
  bit          merr = 0;
  int          due_q[$];
  logic [31:0] dat_q[$];

  function automatic logic [2:0] cls(input logic [31:0] v);
`ifdef FP_RESULT_QUEUE_CLASSIFY_EN
    logic nan, inf, zero;
    nan  = (v[30:23] == 8'hFF) && (v[22:0] != 0);
    inf  = (v[30:23] == 8'hFF) && (v[22:0] == 0);
    zero = (v[30:23] == 8'h00) && (v[22:0] == 0);
    return {nan, inf, zero};
`else
    return 3'b000 & v[2:0];
`endif
  endfunction

  function automatic logic [31:0] rdata();
    logic [31:0] tbl [7];
    tbl[0] = 32'h7FC00000; tbl[1] = 32'h7F800000; tbl[2] = 32'hFF800000; tbl[3] = 32'h00000000;
    tbl[4] = 32'h80000000; tbl[5] = 32'h3F800000; tbl[6] = 32'h7F800001;
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 6)];
    return $urandom;
  endfunction

  function automatic bit mcredit();
    return (mcount + minfl) < DEPTH;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check registered outputs against the model, drive inputs, predict next state.
  task automatic cycle(input bit r, input bit iss, input logic [31:0] idata, input bit ffl,
                       input logic [31:0] fdata, input bit rdy);
    bit          fl;
    logic [31:0] d;
    bit          pop, pushok;
    if (checking) begin
      chk("count", 32'(count), 32'(mcount));
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("credit_ok", 32'(credit_ok), 32'(mcredit()));
      chk("err_overflow", 32'(err_overflow), 32'(merr));
    end
    fl = 0;
    d  = $urandom;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      fl = 1;
      d  = dat_q.pop_front();
      void'(due_q.pop_front());
    end else if (ffl) begin
      fl = 1;
      d  = fdata;
    end
    if (iss) begin
      due_q.push_back(cyc + LAT);
      dat_q.push_back(idata);
    end
    rst = r; issue_i = iss; flag_i = fl; c_i = d; out_ready = rdy;
    if (!r) begin
      sb.delete();
      mcount = 0; minfl = 0; merr = 0;
    end else begin
      pop    = (mcount > 0) && rdy;
      pushok = fl && ((mcount < DEPTH) || pop);
      if (pushok) sb.push_back(d);
      if (fl && !pushok) merr = 1;
      mcount = mcount + int'(pushok) - int'(pop);
      if (iss && !fl) begin
        if (minfl < LAT + DEPTH) minfl++;
      end else if (fl && !iss) begin
        if (minfl > 0) minfl--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!r) checking = 1;
  endtask

  always @(negedge clk) begin
    if (checking && rst && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL head: out_valid=1 but no entry expected (cycle %0d)", cyc);
      end else begin
        chk("out_data", out_data, sb[0]);
        chk("out_class", 32'(out_class), 32'(cls(sb[0])));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] cv [4];
    cv[0] = 32'h7FC00000; cv[1] = 32'h7F800000; cv[2] = 32'h00000000; cv[3] = 32'h3F800000;

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_credit", 32'(credit_ok), 32'd1);
    chk("rst_err", 32'(err_overflow), 32'd0);

    // Single issue, result two cycles later.
    cycle(1, 1, 32'h40400000, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_data", out_data, 32'h40400000);
    chk("one_count", 32'(count), 32'd1);
    chk("one_credit", 32'(credit_ok), 32'd1);
    cycle(0, 0, 0, 0, 0, 0);

    // Fill under credit control with no consumer.
    repeat (12) cycle(1, mcredit(), rdata(), 0, 0, 0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_credit", 32'(credit_ok), 32'd0);
    chk("fill_err", 32'(err_overflow), 32'd0);

    // Forced result into a full queue is dropped.
    cycle(1, 0, 0, 1, 32'hDEADBEEF, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_err", 32'(err_overflow), 32'd1);

    // Push and pop together while full, across pointer wrap.
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 32'h00001000 + 32'(i), 1);
    chk("wrap_count", 32'(count), 32'd4);
    chk("wrap_err", 32'(err_overflow), 32'd1);
    repeat (4) cycle(1, 0, 0, 0, 0, 1);
    chk("drain_count", 32'(count), 32'd0);

    // Class bits.
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, cv[i], 0);
    chk("cls_head", 32'(out_class), 32'(cls(32'h7FC00000)));
    repeat (4) cycle(1, 0, 0, 0, 0, 1);

    // Reset with three stored and two in flight; late results land during reset.
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 32'h3F000000 + 32'(i), 0, 0, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_credit", 32'(credit_ok), 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    chk("post_rst_count", 32'(count), 32'd0);

    // Randomized traffic, occasionally violating credit or injecting spurious results.
    for (int i = 0; i < 400; i++) begin
      bit r, iss;
      r   = ($urandom_range(0, 149) != 0);
      iss = mcredit() ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      cycle(r, iss, rdata(), ($urandom_range(0, 29) == 0), rdata(),
            ($urandom_range(0, 2) != 0));
    end

    for (int k = 0; k < 40 && (mcount != 0 || due_q.size() != 0); k++) cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    chk("end_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_result_queue.md
FP_RESULT_QUEUE -- requirements
Module: fp_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, result-queue entries; power of two, 2..16.
REQ-002 Parameter LAT, default 2, fixed adder latency in cycles from issue to flag_o.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-low (asserted when 0).
REQ-005 issue_i  input  1  upstream launched one operation into the adder this cycle.
REQ-006 flag_i  input  1  adder result valid (adder flag_o).
REQ-007 c_i  input  32 (Float32: sign, 8-bit exponent, 23-bit mantissa)  adder result.
REQ-008 out_ready  input  1  consumer accepts the head entry.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_data  output  32 (Float32)  head entry value.
REQ-011 out_class  output  3  head entry class {nan, inf, zero}.
REQ-012 credit_ok  output  1  upstream may assert issue_i this cycle.
REQ-013 count  output  $clog2(DEPTH)+1  stored entries.
REQ-014 err_overflow  output  1  sticky: a result was dropped.

Function
REQ-015 Circular FIFO of DEPTH entries; write pointer, read pointer, occupancy counter.
REQ-016 Push when flag_i=1 and (count<DEPTH or pop this cycle); entry visible on out_valid the following cycle.
REQ-017 Pop when out_valid=1 and out_ready=1; read pointer advances, next entry presented the following cycle.
REQ-018 out_valid=1 iff count!=0; out_data/out_class driven from the head entry.
REQ-019 Simultaneous push and pop: count unchanged, legal even when full.
REQ-020 Pointers wrap modulo DEPTH.
REQ-021 In-flight counter (0..LAT+DEPTH): +1 on issue_i, -1 on flag_i, unchanged when both occur.
REQ-022 credit_ok = (count + inflight) < DEPTH, combinational from registered state; guarantees no drop when upstream obeys it.
REQ-023 Push attempted while full and not popping: result dropped, pointers unchanged, err_overflow set next cycle.
REQ-024 flag_i with inflight=0 (spurious result): result still pushed if space; inflight held at 0 (no underflow).
REQ-025 issue_i while credit_ok=0: counted in inflight (saturating at its maximum); no other action.
REQ-026 out_ready while out_valid=0: ignored.

Reset
REQ-027 rst=0 at a clock edge clears pointers, count, inflight, err_overflow; out_valid=0, credit_ok=1, count=0, err_overflow=0 the next cycle.
REQ-028 Reset mid-operation discards stored and in-flight results; flag_i during reset is ignored.
REQ-029 Entry storage is not reset; out_data is don't-care while out_valid=0.

Configuration
REQ-030 Macro FP_RESULT_QUEUE_CLASSIFY_EN defined: on push, store class bits: nan = exponent 0xFF and mantissa!=0; inf = exponent 0xFF and mantissa 0; zero = exponent 0 and mantissa 0; presented on out_class with the entry.
REQ-031 Macro undefined: no class storage, out_class tied to 3'b000.

Verification
REQ-032 Reset, then issue_i 1 cycle, flag_i with c_i=0x40400000 two cycles later -> out_valid=1 next cycle, out_data=0x40400000, count=1, credit_ok=1.
REQ-033 DEPTH=4, out_ready=0, issue on every cycle while credit_ok=1 -> credit_ok=0 after 4 issues, exactly 4 entries stored, err_overflow stays 0.
REQ-034 Full queue, force flag_i=1 with out_ready=0 -> entry dropped, count=4, err_overflow=1 until reset.
REQ-035 Full queue, flag_i=1 and out_ready=1 same cycle -> count stays 4, FIFO order preserved across pointer wrap (8 pushes/pops, data in order).
REQ-036 CLASSIFY_EN: push 0x7FC00000, 0x7F800000, 0x00000000, 0x3F800000 -> out_class 100, 010, 001, 000 in order; without macro all 000.
REQ-037 rst=0 with 3 stored and 2 in flight -> next cycle out_valid=0, count=0, credit_ok=1; late flag_i during reset not stored.
